scoreboard_register_file: RTL and testbench

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_read_port.sv | 50 +++++
 rtl/scoreboard_register_file.sv | 96 +++++++++
 tb/tb_scoreboard_register_file.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default widths and port limits.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_MAX = 4;
  // Address of the hardwired zero register.
  localparam int REG_ZERO   = 0;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: address mux over stored data/busy, optional writeback bypass.
// Latency: combinational, same cycle as rd_addr.
// Backpressure: none; a busy register is reported on rd_busy, never stalls the read.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [2**ADDR_W-1:0]             busy,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic                             wr_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             iss_acc,
  input  logic [ADDR_W-1:0]                iss_addr,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_busy
);

`ifdef SCOREBOARD_RF_BYPASS_EN
  logic byp_hit;
  logic byp_busy;

  assign byp_hit  = wr_en && (wr_addr == rd_addr) && (rd_addr != ADDR_W'(REG_ZERO));
  // A same-cycle accepted issue to this register re-reserves it even while bypassing data.
  assign byp_busy = iss_acc && (iss_addr == rd_addr);

  // Stored value unless the writeback in flight targets this address.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
    if (byp_hit) begin
      rd_data = wr_data;
      rd_busy = byp_busy;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{wr_en, wr_addr, wr_data, iss_acc, iss_addr};

  // Stored state only; a same-cycle write shows up on the following cycle.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
  end
`endif

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with per-register busy scoreboard, NUM_RD combinational read ports, WAW issue stall.
// Latency: reads combinational; writes/reservations take effect on the next clk edge. Bypass: SCOREBOARD_RF_BYPASS_EN.
// Backpressure: iss_stall refuses an issue whose target is already reserved; writes are never refused.
module scoreboard_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic [ADDR_W:0]              cnt_nxt;
  logic                         wr_act;
  logic                         iss_acc;

  // Register 0 is excluded from both writes and reservations.
  assign wr_act    = wr_en && (wr_addr != ADDR_W'(REG_ZERO));
  assign iss_stall = iss_en && busy[iss_addr] && (iss_addr != ADDR_W'(REG_ZERO));
  assign iss_acc   = iss_en && !iss_stall && (iss_addr != ADDR_W'(REG_ZERO));

  // Next busy vector: writeback clears, accepted issue sets; the set is applied last so it wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_act) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (iss_acc) begin
      busy_nxt[iss_addr] = 1'b1;
    end
  end

  // Population count of the next busy vector so busy_cnt tracks busy on the same edge.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  // Data storage: one write per cycle, independent of the busy state.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      regs <= '0;
    end else if (wr_act) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state and its registered count.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .regs     (regs),
      .busy     (busy),
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_acc  (iss_acc),
      .iss_addr (iss_addr),
      .rd_data  (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file with hand-computed expectations.
// Latency: checks combinational outputs #1 after input changes, registered outputs #2 after an edge.
// Backpressure: exercises iss_stall on reserved targets.
module tb_scoreboard_register_file;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk;
  logic                     areset_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_stall;
  logic [ADDR_W:0]          busy_cnt;

  int total = 0;
  int bad   = 0;

  scoreboard_register_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_stall (iss_stall),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2**ADDR_W; i++) begin
      set_rd(ADDR_W'(i), ADDR_W'(2**ADDR_W-1-i));
      chk({tag, "_data0"}, 64'(rd_data[31:0]), 64'h0);
      chk({tag, "_data1"}, 64'(rd_data[63:32]), 64'h0);
      chk({tag, "_busy"}, 64'(rd_busy), 64'h0);
    end
  endtask

  initial begin
    areset_n = 1'b0;
    rd_addr  = '0;
    idle();

    // Reset, then every address reads zero and nothing is busy.
    repeat (3) @(posedge clk);
    #3 areset_n = 1'b1;
    #1;
    chk_all_zero("rst_read");
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    iss_en = 1'b1; iss_addr = 5'd9; #1;
    chk("rst_stall", 64'(iss_stall), 64'd0);

    // First edge after release: issue r5 and write r9 together.
    iss_en = 1'b1; iss_addr = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0055;
    tick();
    idle();
    set_rd(5'd5, 5'd9);
    chk("iss5_busy", 64'(rd_busy), 64'b01);
    chk("iss5_cnt", 64'(busy_cnt), 64'd1);
    chk("wr9_data", 64'(rd_data[63:32]), 64'h55);

    // Writeback r5: same-cycle view depends on bypass, then data lands and busy clears.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    set_rd(5'd5, 5'd9);
`ifdef SCOREBOARD_RF_BYPASS_EN
    chk("wb5_same_data", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    chk("wb5_same_busy", 64'(rd_busy), 64'b00);
`else
    chk("wb5_same_data", 64'(rd_data[31:0]), 64'h0);
    chk("wb5_same_busy", 64'(rd_busy), 64'b01);
`endif
    tick();
    idle();
    set_rd(5'd5, 5'd5);
    chk("wb5_data0", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    chk("wb5_data1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
    chk("wb5_busy", 64'(rd_busy), 64'b00);
    chk("wb5_cnt", 64'(busy_cnt), 64'd0);

    // WAW: reserve r7, then a second issue to r7 stalls; r8 is accepted.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    chk("r7_cnt", 64'(busy_cnt), 64'd1);
    iss_en = 1'b1; iss_addr = 5'd7; #1;
    chk("waw7_stall", 64'(iss_stall), 64'd1);
    tick();
    chk("waw7_cnt", 64'(busy_cnt), 64'd1);
    iss_en = 1'b1; iss_addr = 5'd8; #1;
    chk("iss8_stall", 64'(iss_stall), 64'd0);
    tick();
    idle();
    set_rd(5'd7, 5'd8);
    chk("r78_busy", 64'(rd_busy), 64'b11);
    chk("r78_cnt", 64'(busy_cnt), 64'd2);

    // Zero register: write and issue are both ignored.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    set_rd(5'd0, 5'd0);
    chk("r0_stall", 64'(iss_stall), 64'd0);
    chk("r0_same_data", 64'(rd_data[31:0]), 64'h0);
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    chk("r0_data", 64'(rd_data), 64'h0);
    chk("r0_busy", 64'(rd_busy), 64'b00);
    chk("r0_cnt", 64'(busy_cnt), 64'd2);

    // Free r3: write 0x12 and issue r3 together; the reservation wins and data is stored.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12;
    iss_en = 1'b1; iss_addr = 5'd3;
    set_rd(5'd3, 5'd7);
    chk("r3_same_stall", 64'(iss_stall), 64'd0);
`ifdef SCOREBOARD_RF_BYPASS_EN
    chk("r3_same_data", 64'(rd_data[31:0]), 64'h12);
    chk("r3_same_busy", 64'(rd_busy), 64'b11);
`else
    chk("r3_same_data", 64'(rd_data[31:0]), 64'h0);
    chk("r3_same_busy", 64'(rd_busy), 64'b10);
`endif
    tick();
    idle();
    set_rd(5'd3, 5'd3);
    chk("r3_data", 64'(rd_data), {32'h12, 32'h12});
    chk("r3_busy", 64'(rd_busy), 64'b11);
    chk("r3_cnt", 64'(busy_cnt), 64'd3);

    // Busy r7: issue stalls, the write still clears the reservation.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
    iss_en = 1'b1; iss_addr = 5'd7; #1;
    chk("r7_wb_stall", 64'(iss_stall), 64'd1);
    tick();
    idle();
    set_rd(5'd7, 5'd8);
    chk("r7_wb_data", 64'(rd_data[31:0]), 64'hA5);
    chk("r7_wb_busy", 64'(rd_busy), 64'b10);
    chk("r7_wb_cnt", 64'(busy_cnt), 64'd2);

    // Build up four reservations: r3, r8, r7, r10.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    iss_en = 1'b1; iss_addr = 5'd10;
    tick();
    idle();
    chk("four_cnt", 64'(busy_cnt), 64'd4);

    // Asynchronous reset between edges clears everything immediately.
    @(posedge clk);
    #3 areset_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(busy_cnt), 64'd0);
    set_rd(5'd5, 5'd3);
    chk("arst_data", 64'(rd_data), 64'h0);
    chk("arst_busy", 64'(rd_busy), 64'b00);
    @(posedge clk);
    #3 areset_n = 1'b1;
    #1;
    chk_all_zero("arst_read");
    chk("arst_cnt2", 64'(busy_cnt), 64'd0);
    iss_en = 1'b1; iss_addr = 5'd3; #1;
    chk("arst_stall", 64'(iss_stall), 64'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
